// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter. Bytes arrive from the core's
// data-register store strobe, are buffered, and are handed to the transmitter
// one at a time through its data-valid / active / done handshake.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = 4
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Wr_En,
  input  logic [7:0]       i_Wr_Byte,
  input  logic             i_Flush,
  input  logic             i_Clr_Overflow,
  output logic             o_Full,
  output logic             o_Empty,
  output logic [PTR_W:0]   o_Count,
  output logic             o_Overflow,
  output logic             o_Tx_DV,
  output logic [7:0]       o_Tx_Byte,
  input  logic             i_Tx_Active,
  input  logic             i_Tx_Done
);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StSend      = 3'd1;
  localparam logic [2:0] StWaitBusy  = 3'd2;
  localparam logic [2:0] StWaitDone  = 3'd3;
  localparam logic [2:0] StWaitClear = 3'd4;

  localparam logic [PTR_W:0]   CntFull = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CntOne  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q, empty_q;
  logic             ovf_q, ovf_d;
  logic [2:0]       state_q, state_d;
  logic             tx_dv_q, tx_dv_d;
  logic [7:0]       tx_byte_q, tx_byte_d;

  logic is_full;
  logic wr_ok;
  logic ovf_set;
  logic pop;

  // Full/overflow decisions use the pre-edge count; a same-cycle pop does not make room.
  assign is_full = (count_q == CntFull);
  assign wr_ok   = i_Wr_En && !is_full && !i_Flush;
  assign ovf_set = i_Wr_En && is_full;
  // Launch only from idle, and only once the transmitter reports fully quiet.
  assign pop     = (state_q == StIdle) && (count_q != '0) && !i_Tx_Active && !i_Tx_Done;

  // Pointer and occupancy next-state; flush discards everything queued.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (wr_ok) begin
      wp_d = wp_q + PtrOne;
    end
    if (i_Flush) begin
      rp_d    = wp_q;
      count_d = '0;
    end else begin
      if (pop) begin
        rp_d = rp_q + PtrOne;
      end
      if (wr_ok && !pop) begin
        count_d = count_q + CntOne;
      end else if (!wr_ok && pop) begin
        count_d = count_q - CntOne;
      end
    end
  end

  // Sticky overflow; a set in the same cycle as a clear wins.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (i_Clr_Overflow) begin
      ovf_d = 1'b0;
    end
  end

  // Drain handshake sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:      if (pop) state_d = StSend;
      StSend:      state_d = StWaitBusy;
      StWaitBusy:  if (i_Tx_Active) state_d = StWaitDone;
      StWaitDone:  if (i_Tx_Done) state_d = StWaitClear;
      StWaitClear: if (!i_Tx_Done) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Launch strobe and byte are registered so no input reaches them combinationally.
  always_comb begin
    tx_dv_d   = (state_d == StSend);
    tx_byte_d = pop ? mem_q[rp_q] : tx_byte_q;
  end

  // Storage array; no reset needed since contents are only read behind count.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset && wr_ok) begin
      mem_q[wp_q] <= i_Wr_Byte;
    end
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wp_q      <= '0;
      rp_q      <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      state_q   <= StIdle;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      count_q   <= count_d;
      full_q    <= (count_d == CntFull);
      empty_q   <= (count_d == '0);
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign o_Full     = full_q;
  assign o_Empty    = empty_q;
  assign o_Count    = count_q;
  assign o_Overflow = ovf_q;
  assign o_Tx_DV    = tx_dv_q;
  assign o_Tx_Byte  = tx_byte_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-buffering front end for the UART transmitter in the RV32I SoC. Accepts bytes from the core's memory-mapped UART data-register store path into a DEPTH-entry FIFO. Drains them one at a time into the transmitter through its data-valid / active / done handshake. Exposes full, empty, count and a sticky overflow flag for the status register read path.

## Interface
- DEPTH, 16: FIFO entries. Power of two, 2..256.
- PTR_W, 4: pointer width, log2(DEPTH).
- i_Clock  in  1  sole clock; all state updates on its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Wr_En  in  1  one-cycle store strobe from the core bus decoder.
- i_Wr_Byte  in  8  byte to enqueue; sampled when i_Wr_En=1.
- i_Flush  in  1  discard all queued bytes; a byte already launched is not aborted.
- i_Clr_Overflow  in  1  clears o_Overflow.
- o_Full  out  1  count == DEPTH.
- o_Empty  out  1  count == 0.
- o_Count  out  PTR_W+1  entries queued, 0..DEPTH.
- o_Overflow  out  1  sticky; set by a write while full.
- o_Tx_DV  out  1  one-cycle launch pulse to the transmitter.
- o_Tx_Byte  out  8  byte being launched; held stable until the next launch.
- i_Tx_Active  in  1  transmitter busy, from start bit through stop bit.
- i_Tx_Done  in  1  transmitter completion; may stay high for more than one cycle.

## Operation
- Storage: DEPTH x 8 array, write pointer wp, read pointer rp (PTR_W bits each, wrap modulo DEPTH), count register (PTR_W+1 bits).
- Write accepted when i_Wr_En=1 and pre-edge count < DEPTH: mem[wp] <= byte, wp++.
- Write when pre-edge count == DEPTH is dropped and sets o_Overflow, even if a pop occurs in the same cycle.
- Pop happens only on the IDLE->SEND transition: o_Tx_Byte <= mem[rp], rp++.
- Same-cycle accepted write and pop leaves count unchanged; both pointers advance.
- i_Flush: rp <= wp, count <= 0; any same-cycle write is dropped (flush wins). Drain FSM state is unaffected.
- Overflow: set-and-clear in the same cycle leaves o_Overflow=1 (set wins).
- Drain FSM states:
  - IDLE: go to SEND when count != 0, i_Tx_Active=0 and i_Tx_Done=0 (pop here); else stay.
  - SEND: o_Tx_DV=1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when i_Tx_Active=1.
  - WAIT_DONE: go to WAIT_CLEAR when i_Tx_Done=1.
  - WAIT_CLEAR: go to IDLE when i_Tx_Done=0.
  - Any unused encoding: go to IDLE.
- o_Tx_DV is asserted only in SEND and is registered (no combinational path from inputs).

## Timing
- Reset values: o_Tx_DV=0, o_Tx_Byte=8'h00, o_Count=0, o_Empty=1, o_Full=0, o_Overflow=0; FSM=IDLE; wp=rp=0. Array contents are don't-care.
- Reset mid-transfer: returns to IDLE without driving o_Tx_DV. The in-flight byte finishes on the line. The IDLE guard (Active=0, Done=0) blocks the next launch until the transmitter is quiet.
- Status outputs are registered and reflect the post-edge count.
- Latency: write at edge k into an empty FIFO with an idle transmitter gives o_Empty=0 after edge k and o_Tx_DV=1 in the cycle after edge k+1.
- Back-to-back bytes: next launch no earlier than 2 cycles after i_Tx_Done falls (WAIT_CLEAR->IDLE, IDLE->SEND).
- Count wrap: a full FIFO holds exactly DEPTH bytes; pointers wrap with no dead entry.

## Test plan
- Reset, then write 8'h41: o_Tx_DV high exactly 1 cycle, 2 cycles after the write, with o_Tx_Byte=8'h41; o_Count goes 0->1->0.
- Write 16 bytes 8'h00..8'h0F back-to-back with DEPTH=16 and the transmitter model stalled: o_Full=1, o_Count=16. A 17th write sets o_Overflow. Drained bytes leave in order 00..0F and 8'h10 is never sent.
- Simultaneous write and pop at count=3: o_Count stays 3. Assert i_Clr_Overflow together with an overflowing write: o_Overflow stays 1.
- Hold i_Tx_Done high 2 cycles per byte with 3 bytes queued: exactly 3 o_Tx_DV pulses, each after Done falls, and no launch while Done=1.
- Flush with 5 bytes queued while byte 1 is in flight: byte 1 completes; o_Count=0, o_Empty=1; no further o_Tx_DV.
- Assert i_Reset during WAIT_DONE while i_Tx_Active=1: o_Tx_DV stays 0 until the transmitter reports Active=0 and Done=0, then a newly written byte launches normally.
